// File: rtl/ifetch_unit_if.sv
// ---------------------------------------------------------------------------
// ifetch_unit_if
//
// Instruction-memory request/ready handshake between the fetch stage and
// instruction memory. The fetch stage raises imem_req with imem_addr and holds
// both stable until memory answers with imem_ready; imem_rdata is valid only
// in a cycle where imem_ready is high.
//
// Signals:
//   imem_req    fetch side -> memory  fetch request
//   imem_addr   fetch side -> memory  word address of the request
//   imem_rdata  memory -> fetch side  fetched instruction word
//   imem_ready  memory -> fetch side  request completes this cycle
//
// Modports:
//   master  fetch stage (drives req/addr)
//   slave   instruction memory (drives rdata/ready)
// ---------------------------------------------------------------------------
interface ifetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction-fetch stage of the single-cycle MIPS core. Holds the PC, fetches
// one instruction word over the imem handshake, presents it to decode until
// the core commits it, then advances the PC according to the next-PC code
// returned by the control unit.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   EXC_PC    redirect target for a misaligned next PC (IFETCH_MISALIGN_EN)
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   imem         instruction-memory handshake (ifetch_unit_if.master)
//   npc_op       next-PC select: 00 pc+4, 01 branch, 10 jump, 11 register
//   rs_data      register target used when npc_op = 11
//   commit       current instruction retires this cycle
//   instr        latched instruction for decode
//   instr_valid  instr holds a valid instruction awaiting commit
//   pc           address of instr
//   pc_plus4     pc + 4 (combinational), used for link writeback
//   fetch_err    one-cycle pulse after a commit to a misaligned target
//
// Configuration macro:
//   IFETCH_MISALIGN_EN  defined   : misaligned next PC redirects to EXC_PC and
//                                   pulses fetch_err for one cycle
//                       undefined : next PC bits [1:0] are forced to 00 and
//                                   fetch_err is tied low
//
// Sequencing: IDLE (one cycle after reset) -> FETCH (request held until
// imem_ready, commit ignored) -> HOLD (instr_valid, wait for commit) -> FETCH.
// With zero-wait memory this gives one instruction every two cycles.
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic                 clk,
  input  logic                 rst,
  ifetch_unit_if.master        imem,
  input  logic [1:0]           npc_op,
  input  logic [31:0]          rs_data,
  input  logic                 commit,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic                 fetch_err
);

  // Reset and exception vectors must be word addresses.
  if (RESET_PC[1:0] != 2'b00 || EXC_PC[1:0] != 2'b00) begin : g_bad_vector
    $error("ifetch_unit: RESET_PC and EXC_PC must be word aligned");
  end

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic        imem_req_q;

  logic [31:0] branch_off;
  logic [31:0] npc;

  // -------------------------------------------------------------------------
  // Next-PC computation (all adds wrap modulo 2^32)
  // -------------------------------------------------------------------------
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    npc        = pc_plus4;
    unique case (npc_op)
      2'b00: npc = pc_plus4;
      2'b01: npc = pc_plus4 + branch_off;
      2'b10: npc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      2'b11: npc = rs_data;
      default: npc = pc_plus4;
    endcase
  end

`ifdef IFETCH_MISALIGN_EN
  logic fetch_err_q;
  logic misaligned;

  assign misaligned = (npc[1:0] != 2'b00);
  assign fetch_err  = fetch_err_q;
`else
  logic [31:0] npc_aligned;

  assign npc_aligned = npc & ~32'd3;
  assign fetch_err   = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Sequencer with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // Abandons any outstanding request and discards a held instruction.
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
`ifdef IFETCH_MISALIGN_EN
      fetch_err_q   <= 1'b0;
`endif
    end else begin
`ifdef IFETCH_MISALIGN_EN
      fetch_err_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          state_q    <= StFetch;
          imem_req_q <= 1'b1;
        end

        StFetch: begin
          // commit is deliberately not looked at here.
          if (imem.imem_ready) begin
            instr_q       <= imem.imem_rdata;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= StHold;
          end
        end

        StHold: begin
          // imem_ready is ignored; instr stays stable until commit.
          if (commit) begin
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            state_q       <= StFetch;
`ifdef IFETCH_MISALIGN_EN
            if (misaligned) begin
              pc_q        <= EXC_PC;
              fetch_err_q <= 1'b1;
            end else begin
              pc_q        <= npc;
            end
`else
            pc_q <= npc_aligned;
`endif
          end
        end

        default: begin
          state_q       <= StIdle;
          instr_valid_q <= 1'b0;
          imem_req_q    <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign pc             = pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
//
// Directed bench for ifetch_unit: reset state, zero-wait and wait-state
// fetches, next-PC modes (sequential, branch, jump, register), 32-bit wrap,
// misaligned register target, and reset during HOLD and FETCH.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  npc_op = 2'b00;
  logic [31:0] rs_data = 32'h0;
  logic        commit = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c0;

  ifetch_unit_if imem ();

  ifetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem),
    .npc_op      (npc_op),
    .rs_data     (rs_data),
    .commit      (commit),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered with the request expected up; completes after 'waits' idle cycles.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] word,
                       input int waits);
    check({tag, " req"}, {31'h0, imem.imem_req}, 32'd1);
    check({tag, " addr"}, imem.imem_addr, addr);
    imem.imem_ready = 1'b0;
    for (int i = 0; i < waits; i++) begin
      tick();
      check({tag, " wait req"}, {31'h0, imem.imem_req}, 32'd1);
      check({tag, " wait addr"}, imem.imem_addr, addr);
      check({tag, " wait valid"}, {31'h0, instr_valid}, 32'd0);
    end
    imem.imem_rdata = word;
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'hDEAD_BEEF;
    check({tag, " valid"}, {31'h0, instr_valid}, 32'd1);
    check({tag, " instr"}, instr, word);
    check({tag, " pc"}, pc, addr);
    check({tag, " pc_plus4"}, pc_plus4, addr + 32'd4);
    check({tag, " req low"}, {31'h0, imem.imem_req}, 32'd0);
  endtask

  task automatic do_commit(input string tag, input logic [1:0] op, input logic [31:0] rs,
                           input logic [31:0] exp_pc, input logic exp_err);
    npc_op  = op;
    rs_data = rs;
    commit  = 1'b1;
    tick();
    commit  = 1'b0;
    check({tag, " valid low"}, {31'h0, instr_valid}, 32'd0);
    check({tag, " pc"}, pc, exp_pc);
    check({tag, " addr"}, imem.imem_addr, exp_pc);
    check({tag, " req"}, {31'h0, imem.imem_req}, 32'd1);
    check({tag, " fetch_err"}, {31'h0, fetch_err}, {31'h0, exp_err});
  endtask

  initial begin
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'hDEAD_BEEF;

    // Reset state
    tick();
    tick();
    check("rst pc", pc, 32'h0000_3000);
    check("rst valid", {31'h0, instr_valid}, 32'd0);
    check("rst req", {31'h0, imem.imem_req}, 32'd0);
    check("rst instr", instr, 32'h0);
    check("rst fetch_err", {31'h0, fetch_err}, 32'd0);

    // Release: one IDLE cycle, then the request rises
    rst = 1'b0;
    tick();
    fetch("first", 32'h0000_3000, 32'h2008_0005, 0);

    // HOLD ignores imem_ready and keeps instr stable without commit
    imem.imem_rdata = 32'h1111_2222;
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0;
    check("hold instr", instr, 32'h2008_0005);
    check("hold valid", {31'h0, instr_valid}, 32'd1);
    check("hold req", {31'h0, imem.imem_req}, 32'd0);
    tick();
    check("hold2 pc", pc, 32'h0000_3000);

    // Reset wins over commit in HOLD
    rst     = 1'b1;
    commit  = 1'b1;
    npc_op  = 2'b11;
    rs_data = 32'h0000_5000;
    tick();
    commit  = 1'b0;
    check("rst+commit pc", pc, 32'h0000_3000);
    check("rst+commit valid", {31'h0, instr_valid}, 32'd0);
    check("rst+commit req", {31'h0, imem.imem_req}, 32'd0);
    rst = 1'b0;
    tick();

    // Sequential flow with 3 wait cycles; commit during FETCH is ignored
    commit  = 1'b1;
    npc_op  = 2'b11;
    rs_data = 32'h0000_7000;
    fetch("seq0", 32'h0000_3000, 32'h2409_0001, 3);
    commit  = 1'b0;
    do_commit("seq0 c", 2'b00, 32'h0, 32'h0000_3004, 1'b0);
    c0 = cyc;
    fetch("seq1", 32'h0000_3004, 32'h2409_0002, 3);
    do_commit("seq1 c", 2'b00, 32'h0, 32'h0000_3008, 1'b0);
    check("seq cycles", cyc - c0, 32'd5);
    fetch("seq2", 32'h0000_3008, 32'h2409_0003, 3);
    do_commit("to 3010", 2'b11, 32'h0000_3010, 32'h0000_3010, 1'b0);

    // Backward branch: 0x3014 - 12 = 0x3008
    fetch("br", 32'h0000_3010, 32'h1000_FFFD, 0);
    do_commit("br c", 2'b01, 32'h0, 32'h0000_3008, 1'b0);
    fetch("br tgt", 32'h0000_3008, 32'h0000_0000, 0);
    do_commit("to 3020", 2'b11, 32'h0000_3020, 32'h0000_3020, 1'b0);

    // Jump: {0, 0x0000C10, 00} = 0x3040
    fetch("j", 32'h0000_3020, 32'h0800_0C10, 0);
    do_commit("j c", 2'b10, 32'h0, 32'h0000_3040, 1'b0);
    fetch("j tgt", 32'h0000_3040, 32'h03E0_0008, 0);

    // Misaligned register target
`ifdef IFETCH_MISALIGN_EN
    do_commit("jr mis", 2'b11, 32'h0000_3102, 32'h0000_4180, 1'b1);
    tick();
    check("jr mis err pulse end", {31'h0, fetch_err}, 32'd0);
    fetch("exc", 32'h0000_4180, 32'h0000_0000, 0);
`else
    do_commit("jr mis", 2'b11, 32'h0000_3102, 32'h0000_3100, 1'b0);
    tick();
    check("jr mis err stays", {31'h0, fetch_err}, 32'd0);
    fetch("exc", 32'h0000_3100, 32'h0000_0000, 0);
`endif

    // 32-bit wrap: 0xFFFFFFFC + 4 = 0
    do_commit("to top", 2'b11, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    fetch("top", 32'hFFFF_FFFC, 32'h0000_0000, 0);
    do_commit("wrap", 2'b00, 32'h0, 32'h0000_0000, 1'b0);

    // Reset while FETCH waits; a ready during reset must not capture
    tick();
    check("pre-rst waiting", {31'h0, imem.imem_req}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst fetch req", {31'h0, imem.imem_req}, 32'd0);
    imem.imem_rdata = 32'hCAFE_F00D;
    imem.imem_ready = 1'b1;
    tick();
    imem.imem_ready = 1'b0;
    check("late ready instr", instr, 32'h0);
    check("late ready valid", {31'h0, instr_valid}, 32'd0);
    rst = 1'b0;
    tick();
    check("rel addr", imem.imem_addr, 32'h0000_3000);
    check("rel valid", {31'h0, instr_valid}, 32'd0);
    tick();
    check("rel valid2", {31'h0, instr_valid}, 32'd0);
    fetch("recover", 32'h0000_3000, 32'h1234_5678, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
